// File: rtl/cic_pkg.sv
// Shared widths, limits and helpers for the PDM CIC decimator and its optional DC blocker.
package cic_pkg;

   localparam int ACC_W    = 24;
   localparam int NSTAGE   = 3;
   localparam int PCM_W    = 16;
   localparam int PCM_MAX  = 32767;
   localparam int PCM_MIN  = -32768;
   localparam int DC_SHIFT = 8;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [PCM_W-1:0] pcm_t;

   function automatic pcm_t sat_pcm(input acc_t v);
      if (v > acc_t'(PCM_MAX))
         return pcm_t'(PCM_MAX);
      else if (v < acc_t'(PCM_MIN))
         return pcm_t'(PCM_MIN);
      else
         return v[PCM_W-1:0];
   endfunction

endpackage

// File: rtl/dc_block.sv
// One-pole DC blocker y = x - x[n-1] + y[n-1] - (y[n-1]>>>8), one cycle latency.
// Only compiled in when CIC_DC_BLOCK_EN is defined.
`ifdef CIC_DC_BLOCK_EN
module dc_block
   import cic_pkg::*;
(
   input  logic clk_fast,
   input  logic rst,
   input  logic in_valid,
   input  pcm_t in_data,
   output logic out_valid,
   output pcm_t out_data
);

   acc_t x_cur;
   acc_t x_prev;
   acc_t y_prev;
   acc_t y_next;

   always_comb begin
      x_cur  = acc_t'(in_data);
      y_next = x_cur - x_prev + y_prev - (y_prev >>> DC_SHIFT);
   end

   // State advances only on real samples so gaps do not bleed the filter.
   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) begin
         x_prev    <= '0;
         y_prev    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            x_prev   <= x_cur;
            y_prev   <= y_next;
            out_data <= sat_pcm(y_next);
         end
      end
   end

endmodule
`endif

// File: rtl/pdm_cic_decim.sv
// 3-stage CIC decimator, PDM bit stream to 16-bit PCM; pcm_valid 5 cycles after the frame-completing strobe.
// Define CIC_DC_BLOCK_EN to append the dc_block stage (one extra cycle).
module pdm_cic_decim
   import cic_pkg::*;
#(
   parameter int DECIM     = 100,
   parameter int OUT_SHIFT = 5
) (
   input  logic             clk_fast,
   input  logic             rst,
   input  logic             pdm_valid,
   input  logic             pdm_bit,
   output logic             pcm_valid,
   output logic [PCM_W-1:0] pcm_data
);

   localparam int CNT_W = $clog2(DECIM);

   logic [CNT_W-1:0] cnt;
   logic             frame_done;
   acc_t             x;
   acc_t             integ [NSTAGE];
   acc_t             stage [NSTAGE+1];
   logic             vld   [NSTAGE+1];
   acc_t             dly   [NSTAGE];
   acc_t             shifted;
   logic             sat_vld;
   pcm_t             sat_dat;

   assign x = pdm_bit ? acc_t'(1) : acc_t'(-1);

   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (pdm_valid) begin
            if (cnt == CNT_W'(DECIM-1)) begin
               cnt        <= '0;
               frame_done <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   // Integrators run on strobes only; wrap-around is intended and cancels in the combs.
   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NSTAGE; k++)
            integ[k] <= '0;
      end else if (pdm_valid) begin
         integ[0] <= integ[0] + x;
         for (int k = 1; k < NSTAGE; k++)
            integ[k] <= integ[k] + integ[k-1];
      end
   end

   // stage[0] is the decimated capture; each comb subtracts its input from the previous frame.
   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= NSTAGE; k++) begin
            stage[k] <= '0;
            vld[k]   <= 1'b0;
         end
         for (int k = 0; k < NSTAGE; k++)
            dly[k] <= '0;
      end else begin
         vld[0] <= frame_done;
         if (frame_done)
            stage[0] <= integ[NSTAGE-1];
         for (int k = 0; k < NSTAGE; k++) begin
            vld[k+1] <= vld[k];
            if (vld[k]) begin
               stage[k+1] <= stage[k] - dly[k];
               dly[k]     <= stage[k];
            end
         end
      end
   end

   assign shifted = stage[NSTAGE] >>> OUT_SHIFT;

   always_ff @(posedge clk_fast or posedge rst) begin
      if (rst) begin
         sat_vld <= 1'b0;
         sat_dat <= '0;
      end else begin
         sat_vld <= vld[NSTAGE];
         if (vld[NSTAGE])
            sat_dat <= sat_pcm(shifted);
      end
   end

`ifdef CIC_DC_BLOCK_EN
   pcm_t dc_dat;

   dc_block u_dc_block (
      .clk_fast  (clk_fast),
      .rst       (rst),
      .in_valid  (sat_vld),
      .in_data   (sat_dat),
      .out_valid (pcm_valid),
      .out_data  (dc_dat)
   );

   assign pcm_data = dc_dat;
`else
   assign pcm_valid = sat_vld;
   assign pcm_data  = sat_dat;
`endif

endmodule

// File: tb/tb_pdm_cic_decim.sv
// Directed bench for pdm_cic_decim: gain, pattern, gap, latency, saturation and reset cases.
module tb_pdm_cic_decim;

   logic               clk_fast = 1'b0;
   logic               rst;
   logic               pdm_valid;
   logic               pdm_bit;
   logic               pcm_valid;
   logic signed [15:0] pcm_data;
   logic               pcm_valid_s0;
   logic signed [15:0] pcm_data_s0;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc        = 0;
   int strobe_cnt = 0;
   int frame_edge = 0;
   int pulse_val[$];
   int pulse_lat[$];
   int width_err  = 0;
   int stab_err   = 0;
   logic prev_vld = 1'b0;
   int last_data  = 0;

   pdm_cic_decim #(.DECIM(100), .OUT_SHIFT(5)) dut (
      .clk_fast  (clk_fast),
      .rst       (rst),
      .pdm_valid (pdm_valid),
      .pdm_bit   (pdm_bit),
      .pcm_valid (pcm_valid),
      .pcm_data  (pcm_data)
   );

   pdm_cic_decim #(.DECIM(100), .OUT_SHIFT(0)) dut_s0 (
      .clk_fast  (clk_fast),
      .rst       (rst),
      .pdm_valid (pdm_valid),
      .pdm_bit   (pdm_bit),
      .pcm_valid (pcm_valid_s0),
      .pcm_data  (pcm_data_s0)
   );

   always #5 clk_fast = ~clk_fast;

   // Strobe counter model: marks the edge that samples every 100th strobe since reset.
   always @(posedge clk_fast) begin
      cyc = cyc + 1;
      if (rst)
         strobe_cnt = 0;
      else if (pdm_valid) begin
         strobe_cnt = strobe_cnt + 1;
         if (strobe_cnt % 100 == 0)
            frame_edge = cyc;
      end
   end

   always @(negedge clk_fast) begin
      if (rst) begin
         last_data = 0;
         prev_vld  = 1'b0;
      end else begin
         if (pcm_valid) begin
            pulse_val.push_back(int'(pcm_data));
            pulse_lat.push_back(cyc - frame_edge);
            last_data = int'(pcm_data);
            if (prev_vld)
               width_err = width_err + 1;
         end else if (int'(pcm_data) != last_data) begin
            stab_err = stab_err + 1;
         end
         prev_vld = pcm_valid;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_tests = n_tests + 1;
      if (got != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int q_val(input int i);
      return (pulse_val.size() > i) ? pulse_val[i] : -999999;
   endfunction

   function automatic int q_lat(input int i);
      return (pulse_lat.size() > i) ? pulse_lat[i] : -999999;
   endfunction

   task automatic strobe(input logic b, input int gap);
      pdm_valid = 1'b1;
      pdm_bit   = b;
      @(negedge clk_fast);
      if (gap > 0) begin
         pdm_valid = 1'b0;
         repeat (gap) @(negedge clk_fast);
      end
   endtask

   task automatic idle(input int n);
      pdm_valid = 1'b0;
      repeat (n) @(negedge clk_fast);
   endtask

   task automatic do_reset();
      pdm_valid = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk_fast);
      rst = 1'b0;
      pulse_val.delete();
      pulse_lat.delete();
      @(negedge clk_fast);
   endtask

   task automatic chk_lat(input string tag, input int n);
      for (int i = 0; i < n; i++)
         chk(tag, q_lat(i), 5);
   endtask

   initial begin
      rst       = 1'b1;
      pdm_valid = 1'b0;
      pdm_bit   = 1'b0;
      repeat (3) @(negedge clk_fast);
      chk("reset_vld", int'(pcm_valid), 0);
      chk("reset_dat", int'(pcm_data), 0);
      chk("reset_dat_s0", int'(pcm_data_s0), 0);
      rst = 1'b0;
      @(negedge clk_fast);

      // Constant +1, back-to-back strobes.
      for (int i = 0; i < 400; i++) strobe(1'b1, 0);
      idle(10);
      chk("one_npulse", pulse_val.size(), 4);
      chk("one_p0", q_val(0), 5053);
      chk("one_p1", q_val(1), 25884);
      chk("one_p2", q_val(2), 31250);
      chk("one_p3", q_val(3), 31250);
      chk_lat("one_lat", 4);
      chk("sat_hi", int'(pcm_data_s0), 32767);

      // Constant -1.
      do_reset();
      for (int i = 0; i < 400; i++) strobe(1'b0, 0);
      idle(10);
      chk("zero_npulse", pulse_val.size(), 4);
      chk("zero_p0", q_val(0), -5054);
      chk("zero_p2", q_val(2), -31250);
      chk("zero_p3", q_val(3), -31250);
      chk("sat_lo", int'(pcm_data_s0), -32768);

      // Alternating 1/0 settles to zero from the third frame.
      do_reset();
      for (int i = 0; i < 500; i++) strobe((i % 2 == 0) ? 1'b1 : 1'b0, 0);
      idle(10);
      chk("alt_npulse", pulse_val.size(), 5);
      chk("alt_p0", q_val(0), 76);
      chk("alt_p1", q_val(1), 79);
      chk("alt_p2", q_val(2), 0);
      chk("alt_p3", q_val(3), 0);
      chk("alt_p4", q_val(4), 0);

      // One strobe every 100 cycles.
      do_reset();
      for (int i = 0; i < 200; i++) strobe(1'b1, 99);
      idle(10);
      chk("gap_npulse", pulse_val.size(), 2);
      chk("gap_p0", q_val(0), 5053);
      chk("gap_p1", q_val(1), 25884);
      chk_lat("gap_lat", 2);
      idle(40);
      chk("gap_hold", int'(pcm_data), 25884);

      // Reset after 37 strobes of a fresh frame.
      pulse_val.delete();
      pulse_lat.delete();
      for (int i = 0; i < 37; i++) strobe(1'b1, 0);
      pdm_valid = 1'b0;
      rst       = 1'b1;
      #1;
      chk("rst_mid_vld", int'(pcm_valid), 0);
      chk("rst_mid_dat", int'(pcm_data), 0);
      @(negedge clk_fast);
      rst = 1'b0;
      pulse_val.delete();
      pulse_lat.delete();
      for (int i = 0; i < 99; i++) strobe(1'b1, 0);
      idle(10);
      chk("rst_no_early", pulse_val.size(), 0);
      chk("rst_dat_held", int'(pcm_data), 0);
      strobe(1'b1, 0);
      idle(10);
      chk("rst_npulse", pulse_val.size(), 1);
      chk("rst_p0", q_val(0), 5053);
      chk("rst_lat", q_lat(0), 5);

      chk("pulse_width", width_err, 0);
      chk("data_stable", stab_err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pdm_cic_decim.md
PDM_CIC_DECIM -- requirements
Module: pdm_cic_decim

Interface
REQ-001 Parameter DECIM, default 100, decimation ratio (PDM strobes per PCM sample), legal range 8..128.
REQ-002 Parameter OUT_SHIFT, default 5, arithmetic right shift from the comb result to the 16-bit output.
REQ-003 clk_fast  in  1  4.4 MHz fabric clock; single clock domain.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pdm_valid  in  1  one-cycle strobe marking pdm_bit as a new PDM sample.
REQ-006 pdm_bit  in  1  microphone PDM bit; 1 maps to +1 and 0 maps to -1.
REQ-007 pcm_valid  out  1  one-cycle pulse marking a new pcm_data word; feeds the PCM-valid input of the downstream synchronizer.
REQ-008 pcm_data  out  16  signed PCM sample (MIC_PCM), held between pulses.

Function
REQ-009 The block SHALL implement a 3-stage CIC decimator, differential delay 1, with integrators and combs ACC_W = 24 bits wide using two's-complement wrap-around; overflow SHALL NOT be detected or corrected.
REQ-010 The integrators SHALL update only on cycles with pdm_valid=1 and hold otherwise: i1+=x, i2+=i1, i3+=i2, all registered.
REQ-011 A decimation counter SHALL count accepted strobes 0..DECIM-1 and wrap to 0; the strobe seen at count DECIM-1 is the frame-completing strobe.
REQ-012 The cycle after a frame-completing strobe, i3 SHALL be captured into the comb pipeline; the three comb stages SHALL each take one registered cycle (c_k = in - in_prev_frame).
REQ-013 The output stage SHALL apply arithmetic shift by OUT_SHIFT, then saturate to -32768..+32767.
REQ-014 pcm_valid SHALL pulse for exactly one cycle, 5 clk_fast cycles after the edge that sampled the frame-completing strobe (6 cycles with CIC_DC_BLOCK_EN); pcm_data SHALL update on the same cycle.
REQ-015 pcm_data SHALL be held unchanged between pcm_valid pulses.
REQ-016 Gaps of any length between pdm_valid strobes SHALL be tolerated; latency per REQ-014 is measured from the strobe, not wall time.
REQ-017 Back-to-back pdm_valid on every cycle SHALL be supported; DECIM>=8 guarantees the comb pipeline is idle before the next capture.
REQ-018 Nominal gain: DECIM^3 >> OUT_SHIFT; a constant-1 input with defaults yields +31250.

Reset
REQ-019 rst SHALL asynchronously clear integrators, comb registers, comb delay registers, decimation counter and the DC-block state to 0.
REQ-020 During and after reset, pcm_valid=0 and pcm_data=0.
REQ-021 Reset mid-frame SHALL discard the partial frame and any in-flight comb result; the first pcm_valid after release SHALL follow the DECIM-th strobe after release.

Configuration
REQ-022 Macro CIC_DC_BLOCK_EN defined: a DC-blocking stage y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1]>>>8) SHALL be inserted after saturation, with internal width 24 bits, a final 16-bit saturation, and one added cycle of latency.
REQ-023 Macro CIC_DC_BLOCK_EN undefined: no DC-block logic SHALL be present, and latency SHALL be per REQ-014 base.

Structure
REQ-024 Package cic_pkg SHALL hold ACC_W, the stage count (3), PCM_W (16), the saturation limits and the DC-block shift (8).
REQ-025 The DC blocker SHALL be a separate sub-module, dc_block, instantiated only under CIC_DC_BLOCK_EN; the integrator and comb chains remain inline.

Verification
REQ-026 Constant pdm_bit=1 with strobes every cycle -> after 3 frames pcm_data=+31250; constant 0 -> -31250.
REQ-027 Alternating 1/0 pattern -> after 3 frames pcm_data=0 on every pulse.
REQ-028 Strobe every 100 cycles -> pcm_valid exactly 5 cycles after each 100th strobe, one cycle wide, pcm_data stable in between.
REQ-029 Assert rst after 37 strobes -> outputs 0 immediately; the next pcm_valid follows the 100th strobe after release.
REQ-030 OUT_SHIFT=0 with constant 1 -> pcm_data clamps to +32767; constant 0 -> -32768.
REQ-031 With CIC_DC_BLOCK_EN, constant 1 -> the first settled output near +31250 decays monotonically toward 0 within 2000 frames; latency is 6 cycles.
